// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg -- shared constants and helpers for the pipelined data memory.
//
// Contents:
//   WORD_W / RESP_W       : data word width and response entry width {err,data}
//   BYTE .. HALF_UNSIGNED : RISC-V load/store funct3 encodings
//   store_be()            : byte-lane enables for a store
//   store_lanes()         : store data replicated onto the byte lanes
//   load_extract()        : select and extend load data from a RAM word
//   access_fault()        : misalignment / illegal-funct3 detection, used only
//                           when DMEM_MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int RESP_W = WORD_W + 1;

    localparam logic [2:0] BYTE          = 3'b000;
    localparam logic [2:0] HALF          = 3'b001;
    localparam logic [2:0] WORD          = 3'b010;
    localparam logic [2:0] BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] HALF_UNSIGNED = 3'b101;

    // Halfwords only look at off[1]; any funct3 that is not a byte or
    // halfword store is treated as a full-word store.
    function automatic logic [3:0] store_be(input logic [2:0] size,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the data onto every candidate lane lets the byte enables
    // alone decide what lands in the RAM.
    function automatic logic [WORD_W-1:0] store_lanes(input logic [2:0] size,
                                                      input logic [WORD_W-1:0] wdata);
        logic [WORD_W-1:0] lanes;
        case (size)
            BYTE:    lanes = {4{wdata[7:0]}};
            HALF:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [WORD_W-1:0] load_extract(input logic [2:0] size,
                                                       input logic [1:0] off,
                                                       input logic [WORD_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [WORD_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:          r = {{24{b[7]}}, b};
            HALF:          r = {{16{h[15]}}, h};
            BYTE_UNSIGNED: r = {24'd0, b};
            HALF_UNSIGNED: r = {16'd0, h};
            default:       r = word;
        endcase
        return r;
    endfunction

    // Loads may use 000/001/010/100/101; stores only 000/001/010.
    function automatic logic access_fault(input logic       write,
                                          input logic [2:0] size,
                                          input logic [1:0] off);
        logic f;
        case (size)
            BYTE:          f = 1'b0;
            HALF:          f = off[0];
            WORD:          f = (off != 2'b00);
            BYTE_UNSIGNED: f = write;
            HALF_UNSIGNED: f = write | off[0];
            default:       f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// -----------------------------------------------------------------------------
// dmem_resp_fifo -- small response FIFO holding {err, data} entries.
//
// Parameters:
//   RESP_DEPTH : number of entries (>= 2, need not be a power of two)
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   push       : write push_data (caller guarantees the FIFO is not full)
//   push_data  : {err, data} entry
//   pop        : consume the head entry (ignored while empty)
//   pop_data   : head entry, forced to zero while the FIFO is empty
//   count      : current number of entries
// -----------------------------------------------------------------------------
module dmem_resp_fifo
    import dmem_pkg::*;
#(
    parameter int RESP_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              push,
    input  logic [RESP_W-1:0]                 push_data,
    input  logic                              pop,
    output logic [RESP_W-1:0]                 pop_data,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [RESP_W-1:0] entry_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count_reg != '0);

    // Entry storage is deliberately not reset; only pointers/count are.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Gating on count makes the outputs drop to zero as soon as reset clears it.
    assign pop_data = (count_reg != '0) ? entry_mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

endmodule

// File: rtl/dmem_pipelined.sv
// -----------------------------------------------------------------------------
// dmem_pipelined -- pipelined byte-addressable data memory with a
// valid/ready request channel and a buffered, in-order response channel.
//
// Parameters:
//   DEPTH      : RAM size in 32-bit words (power of two, >= 4)
//   ADDR_W     : byte-address width
//   RESP_DEPTH : response buffer entries (>= 2)
// Ports:
//   clk, rstn                        : clock, asynchronous active-low reset
//   reqValid/reqReady                : request handshake
//   reqWrite, reqAddr, reqSize,
//   reqWdata                         : store/load, byte address, funct3, data
//   respValid/respReady              : response handshake
//   respRdata, respErr               : extended load data, fault flag
//
// Pipeline: the accepting edge latches the request into s1 and performs the
// RAM read; s1 performs the store write and pushes the response on the next
// edge. A load accepted while a store to the same word sits in s1 takes the
// stored lanes through a bypass so it sees the updated data.
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses and
// illegal funct3 (respErr=1, respRdata=0, RAM untouched). Without it respErr
// stays 0 and addresses/funct3 are coerced.
// -----------------------------------------------------------------------------
module dmem_pipelined
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [2:0]        reqSize,
    input  logic [WORD_W-1:0] reqWdata,
    output logic              respValid,
    input  logic              respReady,
    output logic [WORD_W-1:0] respRdata,
    output logic              respErr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic              accept;
    logic              pop;
    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        req_off;
    logic              req_err;

    logic              s1_valid_reg;
    logic              s1_write_reg;
    logic              s1_err_reg;
    logic [2:0]        s1_size_reg;
    logic [1:0]        s1_off_reg;
    logic [IDX_W-1:0]  s1_idx_reg;
    logic [3:0]        s1_be_reg;
    logic [WORD_W-1:0] s1_lanes_reg;

    logic [WORD_W-1:0] ram_rd_word;
    logic [RESP_W-1:0] push_data;
    logic [RESP_W-1:0] head_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    outstanding;

    assign req_idx = reqAddr[IDX_W+1:2];
    assign req_off = reqAddr[1:0];

    // Address bits above the RAM index are intentionally ignored.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^reqAddr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_err = access_fault(reqWrite, reqSize, req_off);
`else
    assign req_err = 1'b0;
`endif

    // ---------------------------------------------------------------- handshake
    // Every request in s1 or in the FIFO holds a reserved FIFO slot; a pop in
    // the same cycle frees one, so reqReady depends combinationally on respReady.
    assign respValid   = (fifo_count != '0);
    assign pop         = respValid && respReady;
    assign outstanding = {{CNT_W{1'b0}}, s1_valid_reg} + {1'b0, fifo_count};
    assign reqReady    = (outstanding < (CNT_W + 1)'(RESP_DEPTH)) || pop;
    assign accept      = reqValid && reqReady;

    // ---------------------------------------------------------------- stage s1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg <= 1'b0;
            s1_write_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_size_reg  <= '0;
            s1_off_reg   <= '0;
            s1_idx_reg   <= '0;
            s1_be_reg    <= '0;
            s1_lanes_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_write_reg <= reqWrite;
                s1_err_reg   <= req_err;
                s1_size_reg  <= reqSize;
                s1_off_reg   <= req_off;
                s1_idx_reg   <= req_idx;
                s1_be_reg    <= store_be(reqSize, req_off);
                s1_lanes_reg <= store_lanes(reqSize, reqWdata);
            end
        end
    end

    // ---------------------------------------------------------------- RAM
    // One byte-wide RAM per lane gives per-lane write enables without
    // read-modify-write. The write is gated by s1_valid_reg, so a store caught
    // in s1 by reset is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;
            logic       lane_we;
            logic [7:0] lane_wdata;

            assign lane_we    = s1_valid_reg && s1_write_reg && !s1_err_reg && s1_be_reg[gi];
            assign lane_wdata = s1_lanes_reg[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    lane_mem[s1_idx_reg] <= lane_wdata;
                end
                if (accept) begin
                    // Same-edge write to the word being read: forward new lane.
                    if (lane_we && (s1_idx_reg == req_idx)) begin
                        lane_rd_reg <= lane_wdata;
                    end else begin
                        lane_rd_reg <= lane_mem[req_idx];
                    end
                end
            end

            assign ram_rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    // ---------------------------------------------------------------- response
    assign push_data = {s1_err_reg,
                        (s1_write_reg || s1_err_reg) ? '0
                                                     : load_extract(s1_size_reg, s1_off_reg, ram_rd_word)};

    dmem_resp_fifo #(
        .RESP_DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s1_valid_reg),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (fifo_count)
    );

    assign respRdata = head_data[WORD_W-1:0];
    assign respErr   = head_data[WORD_W];

endmodule

// File: tb/tb_dmem_pipelined.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipelined -- self-checking bench for dmem_pipelined.
// Expected responses are queued when a request is accepted and compared in
// order by a response monitor. Runs with RESP_DEPTH=3 so that two buffered
// responses plus a store in s1 can coexist.
// -----------------------------------------------------------------------------
module tb_dmem_pipelined;
    import dmem_pkg::*;

    localparam int TB_DEPTH = 256;
    localparam int TB_ADDR_W = 32;
    localparam int TB_RD = 3;
    localparam logic [32:0] OK0 = 33'd0;
    localparam logic [32:0] ERR = {1'b1, 32'd0};

    logic        clk = 1'b0;
    logic        rstn;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [2:0]  reqSize;
    logic [31:0] reqWdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          resp_seen = 0;
    int          rise_q[$];
    logic [32:0] exp_q[$];
    logic        prev_valid = 1'b0;

    dmem_pipelined #(
        .DEPTH      (TB_DEPTH),
        .ADDR_W     (TB_ADDR_W),
        .RESP_DEPTH (TB_RD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqAddr   (reqAddr),
        .reqSize   (reqSize),
        .reqWdata  (reqWdata),
        .respValid (respValid),
        .respReady (respReady),
        .respRdata (respRdata),
        .respErr   (respErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] okd(input logic [31:0] d);
        return {1'b0, d};
    endfunction

    // Response monitor: samples mid-cycle, pops and compares in order.
    always @(negedge clk) begin
        logic [32:0] expv;
        if (respValid === 1'b1 && prev_valid !== 1'b1) rise_q.push_back(cyc);
        prev_valid = respValid;
        if (rstn === 1'b1 && respValid === 1'b1 && respReady === 1'b1) begin
            resp_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL resp_unexpected: got err=%0b data=%08h, required no response", respErr, respRdata);
            end else begin
                expv = exp_q.pop_front();
                $display("[TB] resp %0d: err=%0b data=%08h (expected err=%0b data=%08h)",
                         resp_seen, respErr, respRdata, expv[32], expv[31:0]);
                if ({respErr, respRdata} !== expv) begin
                    tests_failed++;
                    $display("FAIL resp_data: got err=%0b data=%08h, required err=%0b data=%08h",
                             respErr, respRdata, expv[32], expv[31:0]);
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns just after the
    // accepting edge with reqValid still high so calls can run back to back.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [32:0] expv,
                        output int acc_cyc, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        acc_cyc = -1;
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqSize  = size;
        reqWdata = wdata;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (reqReady === 1'b1) begin
                acc_cyc = cyc;
                exp_q.push_back(expv);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_timeout: addr=%08h not accepted within 64 cycles, required acceptance", addr);
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                      input logic [32:0] e);
        int unused_c, unused_s;
        send(1'b1, a, f, d, e, unused_c, unused_s);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic [32:0] e);
        int unused_c, unused_s;
        send(1'b0, a, f, 32'd0, e, unused_c, unused_s);
    endtask

    task automatic idle();
        reqValid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        reqValid  = 1'b0;
        respReady = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && respValid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rstn = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqSize = '0; reqWdata = '0;
        respReady = 1'b0;
        #1;
        tests_run += 3;
        if (respValid !== 1'b0) begin tests_failed++; $display("FAIL reset_respValid: got %b, required 0", respValid); end
        if (respRdata !== 32'd0) begin tests_failed++; $display("FAIL reset_respRdata: got %08h, required 00000000", respRdata); end
        if (respErr !== 1'b0) begin tests_failed++; $display("FAIL reset_respErr: got %b, required 0", respErr); end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        respReady = 1'b1;
        @(negedge clk);
        tests_run += 2;
        if (reqReady !== 1'b1) begin tests_failed++; $display("FAIL reset_reqReady: got %b, required 1", reqReady); end
        if (respValid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_valid: got %b, required 0", respValid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_spec_vectors();
        st(32'h10, WORD, 32'hDEADBEEF, OK0);
        ld(32'h13, BYTE, okd(32'hFFFFFFDE));
        ld(32'h13, BYTE_UNSIGNED, okd(32'h000000DE));
        ld(32'h12, HALF, okd(32'hFFFFDEAD));
        ld(32'h10, HALF_UNSIGNED, okd(32'h0000BEEF));
        ld(32'h10, BYTE, okd(32'hFFFFFFEF));
        ld(32'h11, BYTE_UNSIGNED, okd(32'h000000BE));
        ld(32'h10 + TB_DEPTH * 4, WORD, okd(32'hDEADBEEF));   // aliased high bits
        st(TB_DEPTH * 4 - 4, WORD, 32'hFEEDFACE, OK0);          // last word
        ld(TB_DEPTH * 4 - 4, WORD, okd(32'hFEEDFACE));
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        st(32'h10, WORD, 32'h11223344, OK0);
        st(32'h11, BYTE, 32'h000000AA, OK0);
        ld(32'h10, WORD, okd(32'h1122AA44));
        st(32'h12, HALF, 32'h0000BEEF, OK0);
        ld(32'h10, WORD, okd(32'hBEEFAA44));
        st(32'h13, BYTE, 32'h00000077, OK0);
        ld(32'h13, BYTE_UNSIGNED, okd(32'h00000077));
        st(32'h14, WORD, 32'hFFFFFFFF, OK0);                    // other word: no forwarding
        ld(32'h10, WORD, okd(32'h77EFAA44));
        idle();
        drain();
    endtask

    task automatic test_throughput();
        int acc0, acc_last, stalls, total_stalls, seen0, c, s;
        for (int i = 0; i < 16; i++) st(32'h100 + 4 * i, WORD, 32'hC0DE0000 + i, OK0);
        idle();
        drain();
        rise_q.delete();
        seen0 = resp_seen;
        total_stalls = 0;
        acc0 = -1;
        acc_last = -1;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 32'h100 + 4 * i, WORD, 32'd0, okd(32'hC0DE0000 + i), c, s);
            if (i == 0) acc0 = c;
            acc_last = c;
            total_stalls += s;
        end
        idle();
        drain();
        tests_run += 4;
        if (total_stalls !== 0) begin tests_failed++; $display("FAIL tput_stalls: got %0d, required 0", total_stalls); end
        if (acc_last - acc0 !== 15) begin tests_failed++; $display("FAIL tput_span: got %0d cycles, required 15", acc_last - acc0); end
        if (resp_seen - seen0 !== 16) begin tests_failed++; $display("FAIL tput_count: got %0d, required 16", resp_seen - seen0); end
        if (rise_q.size() == 0 || rise_q[0] - acc0 !== 2) begin
            tests_failed++;
            $display("FAIL tput_latency: got %0d, required 2", (rise_q.size() == 0) ? -1 : rise_q[0] - acc0);
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        accepted = 0;
        respReady = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h100; reqSize = WORD; reqWdata = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (reqReady === 1'b1) begin
                accepted++;
                exp_q.push_back(okd(32'hC0DE0000));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        tests_run += 2;
        if (accepted !== TB_RD) begin tests_failed++; $display("FAIL bp_accepted: got %0d, required %0d", accepted, TB_RD); end
        if (reqReady !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %b, required 0", reqReady); end
        @(posedge clk);
        #1;
        respReady = 1'b1;
        @(negedge clk);
        tests_run += 2;
        if (respValid !== 1'b1) begin tests_failed++; $display("FAIL bp_pop_valid: got %b, required 1", respValid); end
        if (reqReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_resume: got reqReady=%b, required 1", reqReady);
        end else begin
            exp_q.push_back(okd(32'hC0DE0000));
        end
        @(posedge clk);
        #1;
        idle();
        drain();
    endtask

    task automatic test_misalign();
        st(32'h20, WORD, 32'hCAFEF00D, OK0);
`ifdef DMEM_MISALIGN_TRAP_EN
        st(32'h21, WORD, 32'h12345678, ERR);
        ld(32'h20, WORD, okd(32'hCAFEF00D));
        ld(32'h23, HALF_UNSIGNED, ERR);
        ld(32'h20, 3'b011, ERR);
        st(32'h20, BYTE_UNSIGNED, 32'h000000EE, ERR);
        ld(32'h20, WORD, okd(32'hCAFEF00D));
`else
        st(32'h21, WORD, 32'h12345678, OK0);
        ld(32'h20, WORD, okd(32'h12345678));
        ld(32'h23, HALF_UNSIGNED, okd(32'h00001234));
        ld(32'h20, 3'b011, okd(32'h12345678));
        st(32'h20, BYTE_UNSIGNED, 32'h000000EE, OK0);
        ld(32'h20, WORD, okd(32'h000000EE));
`endif
        idle();
        drain();
    endtask

    task automatic test_reset_midflight();
        int seen0;
        st(32'h40, WORD, 32'h55AA55AA, OK0);
        idle();
        drain();
        respReady = 1'b0;
        ld(32'h40, WORD, okd(32'h55AA55AA));
        ld(32'h40, WORD, okd(32'h55AA55AA));
        st(32'h40, WORD, 32'h99999999, OK0);
        idle();
        rstn = 1'b0;                      // store now in s1, two responses buffered
        exp_q.delete();
        #1;
        tests_run += 3;
        if (respValid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b, required 0", respValid); end
        if (respRdata !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_rdata: got %08h, required 00000000", respRdata); end
        if (respErr !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_err: got %b, required 0", respErr); end
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        respReady = 1'b1;
        seen0 = resp_seen;
        repeat (5) @(negedge clk);
        tests_run += 2;
        if (resp_seen - seen0 !== 0) begin tests_failed++; $display("FAIL rst_mid_noresp: got %0d responses, required 0", resp_seen - seen0); end
        if (reqReady !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b, required 1", reqReady); end
        @(posedge clk);
        #1;
        ld(32'h40, WORD, okd(32'h55AA55AA));
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_throughput();
        test_backpressure();
        test_misalign();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
